traffic_sensor_frontend: RTL
============================

Name: traffic_sensor_frontend

Overview:
- Vehicle-detector front end that produces the lane request inputs (input_a, input_b) for traffic_light_fsm and consumes its light outputs (output_x, output_y, output_z) as service acknowledgements.
- Per lane: synchronises and debounces the raw loop-detector signal, counts queued vehicles, drains the queue while that lane is green, and raises a request and an urgency flag.
- Sits beside u_fsm inside traffic_light_control.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples required to accept a detector level change; legal range >=1.
- QUEUE_W, 4, width of each lane's queue counter.
- MIN_QUEUE, 1, queue depth at which a lane request asserts; legal range 1..2^QUEUE_W-1.
- DEPART_CYCLES, 8, cycles per vehicle departure while the lane is green.
- MAX_WAIT, 64, cycles a non-empty, unserved lane waits before its urgent flag sets.

Ports:
- clk  in  1  system clock.
- rstb  in  1  asynchronous active-low reset.
- det_a_raw  in  1  raw loop detector, lane A; asynchronous to clk.
- det_b_raw  in  1  raw loop detector, lane B; asynchronous to clk.
- output_x  in  1  lane A green, from FSM.
- output_y  in  1  lane B green, from FSM.
- output_z  in  1  amber, from FSM; no departures occur while high.
- input_a  out  1  lane A service request to FSM.
- input_b  out  1  lane B service request to FSM.
- urgent_a  out  1  lane A has waited MAX_WAIT cycles.
- urgent_b  out  1  lane B has waited MAX_WAIT cycles.
- queue_a  out  QUEUE_W  lane A vehicle count.
- queue_b  out  QUEUE_W  lane B vehicle count.

Behaviour:
- Reset: rstb is asynchronous and active-low. While rstb=0, all outputs, counters, synchronisers and filtered levels are 0 and both lane FSMs are in IDLE. Reset asserted mid-operation discards all queued vehicles.
- Synchroniser: each det_*_raw passes through a 2-flop synchroniser.
- Debounce: a counter increments while the synchronised value differs from the filtered level and clears when they match. The filtered level takes the new value once the synchronised value has differed for DEBOUNCE_CYCLES consecutive cycles. Shorter glitches are ignored.
- Arrival: a filtered rising edge is one arrival and increments the queue, saturating at 2^QUEUE_W-1.
- Departure: while the lane's green is high and output_z=0, a per-lane departure timer counts. Every DEPART_CYCLES cycles the queue decrements, saturating at 0. The timer clears when green drops.
- Arrival and departure in the same cycle: queue unchanged.
- Per-lane FSM, all outputs registered:
  - IDLE: queue=0. Go to WAITING when queue>=1.
  - WAITING: queue>0 and lane not green; the wait counter increments. Go to SERVING when green rises. Go to IDLE if the queue reaches 0.
  - SERVING: lane green; the wait counter is held at 0. On green falling, go to WAITING if queue>0, else IDLE.
- urgent_*: sets when the wait counter reaches MAX_WAIT. Clears on entry to SERVING or IDLE. The wait counter saturates at MAX_WAIT.
- input_*: asserted when queue>=MIN_QUEUE or urgent_* is high; deasserted otherwise. Also deasserted while the lane is in SERVING with queue=0.
- Latency: raw level change to filtered change is DEBOUNCE_CYCLES+2 cycles. Queue updates 1 cycle later and input_* 1 cycle after that, for DEBOUNCE_CYCLES+4 cycles total.
- Both greens high in the same cycle is illegal input. Both lanes then drain independently; no error is flagged unless the optional feature is enabled.

Optional Feature:
- Macro: TRAFFIC_SENSOR_STATS_EN.
- Defined: adds outputs total_a[15:0], total_b[15:0] and conflict_err.
  - total_*: lifetime arrival counts per lane; they wrap at 16'hFFFF to 0.
  - conflict_err: sticky error, set when output_x and output_y are both high. Cleared only by reset.
- Undefined: these ports, counters and the error flop are not present.

Test Plan:
- Reset with det_a_raw=1 held -> all outputs 0 during reset; after release, input_a rises exactly 8 cycles after the first post-reset clk edge (DEBOUNCE_CYCLES=4), with queue_a=1.
- 3-cycle pulse on det_b_raw -> queue_b stays 0 and input_b stays 0; a 6-cycle pulse -> queue_b=1.
- 20 clean arrivals on lane A (QUEUE_W=4) -> queue_a saturates at 15; then hold output_x=1 -> queue_a decrements every 8 cycles and reaches 0 after 120 cycles; input_a drops on the cycle after queue_a reaches 0.
- Arrival debounced on the same cycle as a departure tick -> queue_a unchanged (e.g. stays at 5).
- Lane B queue=1 with no green for 64 cycles -> urgent_b=1; assert output_y -> urgent_b=0 on the next cycle.
- Assert rstb=0 mid-drain with queue_a=7 -> queue_a=0 asynchronously; with TRAFFIC_SENSOR_STATS_EN defined, output_x=output_y=1 -> conflict_err=1 until reset.

Source files
------------

// File: rtl/traffic_sensor_frontend_if.sv
// Signal bundle between traffic_sensor_frontend (master) and traffic_light_fsm (slave).
// Defining TRAFFIC_SENSOR_STATS_EN adds the arrival totals and the green-conflict flag.
interface traffic_sensor_frontend_if #(
  parameter int QUEUE_W = 4
);
  logic               output_x;
  logic               output_y;
  logic               output_z;
  logic               input_a;
  logic               input_b;
  logic               urgent_a;
  logic               urgent_b;
  logic [QUEUE_W-1:0] queue_a;
  logic [QUEUE_W-1:0] queue_b;
`ifdef TRAFFIC_SENSOR_STATS_EN
  logic [15:0]        total_a;
  logic [15:0]        total_b;
  logic               conflict_err;
`endif

  modport master (
    input  output_x, output_y, output_z,
    output input_a, input_b, urgent_a, urgent_b, queue_a, queue_b
`ifdef TRAFFIC_SENSOR_STATS_EN
    , output total_a, total_b, conflict_err
`endif
  );

  modport slave (
    output output_x, output_y, output_z,
    input  input_a, input_b, urgent_a, urgent_b, queue_a, queue_b
`ifdef TRAFFIC_SENSOR_STATS_EN
    , input total_a, total_b, conflict_err
`endif
  );
endinterface

// File: rtl/traffic_sensor_frontend.sv
// Two-lane loop-detector front end producing request/urgency inputs for traffic_light_fsm.
// Define TRAFFIC_SENSOR_STATS_EN for lifetime arrival totals and a sticky green-conflict flag.
module traffic_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_W         = 4,
  parameter int MIN_QUEUE       = 1,
  parameter int DEPART_CYCLES   = 8,
  parameter int MAX_WAIT        = 64
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      det_a_raw,
  input  logic                      det_b_raw,
  traffic_sensor_frontend_if.master sensor
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DT_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam int WT_W = $clog2(MAX_WAIT + 1);
  localparam logic [QUEUE_W-1:0] Q_FULL  = '1;
  localparam logic [QUEUE_W-1:0] Q_MIN   = QUEUE_W'(MIN_QUEUE);
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DT_W-1:0]    DT_LAST = DT_W'(DEPART_CYCLES - 1);
  localparam logic [WT_W-1:0]    WT_MAX  = WT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WAITING, SERVING} lane_state_t;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    logic               det_raw;
    logic               green;
    logic [1:0]         sync;
    logic               filt;
    logic               filt_d;
    logic [DB_W-1:0]    db_cnt;
    logic [DT_W-1:0]    dep_tmr;
    logic [QUEUE_W-1:0] queue;
    logic [QUEUE_W-1:0] queue_next;
    logic [WT_W-1:0]    wait_cnt;
    logic [WT_W-1:0]    wait_next;
    lane_state_t        state;
    lane_state_t        state_next;
    logic               urgent;
    logic               urgent_next;
    logic               req;
    logic               req_next;
    logic               arrive;
    logic               depart;

    assign det_raw = (i == 0) ? det_a_raw : det_b_raw;
    assign green   = (i == 0) ? sensor.output_x : sensor.output_y;
    assign arrive  = filt & ~filt_d;
    assign depart  = green & ~sensor.output_z & (dep_tmr == DT_LAST);

    // Filtered level only follows the synchronised input after DEBOUNCE_CYCLES straight disagreements.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        sync   <= '0;
        filt   <= 1'b0;
        filt_d <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync   <= {sync[0], det_raw};
        filt_d <= filt;
        if (sync[1] == filt) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          filt   <= sync[1];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    // A simultaneous arrival and departure cancel out, even at the saturation limits.
    always_comb begin
      queue_next = queue;
      if (arrive && !depart) begin
        if (queue != Q_FULL) queue_next = queue + QUEUE_W'(1);
      end else if (depart && !arrive) begin
        if (queue != '0) queue_next = queue - QUEUE_W'(1);
      end
    end

    always_comb begin
      state_next  = state;
      wait_next   = wait_cnt;
      urgent_next = urgent;
      unique case (state)
        IDLE:    if (queue != '0) state_next = WAITING;
        WAITING: begin
          if (queue == '0)  state_next = IDLE;
          else if (green)   state_next = SERVING;
          if (wait_cnt != WT_MAX) wait_next = wait_cnt + WT_W'(1);
        end
        SERVING: if (!green) state_next = (queue != '0) ? WAITING : IDLE;
        default: state_next = IDLE;
      endcase
      if (state_next != WAITING) begin
        wait_next   = '0;
        urgent_next = 1'b0;
      end else if (wait_next == WT_MAX) begin
        urgent_next = 1'b1;
      end
      req_next = ((queue >= Q_MIN) || urgent) && !((state == SERVING) && (queue == '0));
    end

    // Departure timer holds through amber and restarts whenever the green drops.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        dep_tmr  <= '0;
        queue    <= '0;
        state    <= IDLE;
        wait_cnt <= '0;
        urgent   <= 1'b0;
        req      <= 1'b0;
      end else begin
        if (!green)                    dep_tmr <= '0;
        else if (!sensor.output_z)     dep_tmr <= depart ? '0 : dep_tmr + DT_W'(1);
        queue    <= queue_next;
        state    <= state_next;
        wait_cnt <= wait_next;
        urgent   <= urgent_next;
        req      <= req_next;
      end
    end

`ifdef TRAFFIC_SENSOR_STATS_EN
    logic [15:0] total;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)       total <= '0;
      else if (arrive) total <= total + 16'd1;
    end
`endif
  end

  assign sensor.input_a  = g_lane[0].req;
  assign sensor.input_b  = g_lane[1].req;
  assign sensor.urgent_a = g_lane[0].urgent;
  assign sensor.urgent_b = g_lane[1].urgent;
  assign sensor.queue_a  = g_lane[0].queue;
  assign sensor.queue_b  = g_lane[1].queue;

`ifdef TRAFFIC_SENSOR_STATS_EN
  logic conflict_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                                   conflict_q <= 1'b0;
    else if (sensor.output_x && sensor.output_y) conflict_q <= 1'b1;
  end

  assign sensor.conflict_err = conflict_q;
  assign sensor.total_a      = g_lane[0].total;
  assign sensor.total_b      = g_lane[1].total;
`endif
endmodule
